// File: rtl/dff_share_arb.sv
`default_nettype none
// ============================================================================
// Module     : dff_share_arb
// Description: Round-robin arbiter and write sequencer for a shared register,
//              granting one requester at a time under a 4-phase req/ack.
// Revision   : 1.0
// ============================================================================
module dff_share_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
    output logic [IW-1:0]         owner,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     ptr_n;
    logic [IW-1:0]     owner_n;
    logic [WIDTH-1:0]  q_n;
    logic              q_valid_n;
    logic [NREQ-1:0]   ack_n;
    logic [IW-1:0]     winner;
    logic [IW-1:0]     idx;
    logic              found;
    logic [WIDTH-1:0]  slice [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign slice[g] = wdata[g*WIDTH +: WIDTH];
    end

    // First asserted request scanning upward from ptr, wrapping at NREQ-1.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        owner_n   = owner;
        q_n       = q;
        q_valid_n = q_valid;
        ack_n     = ack;
        case (state)
            IDLE: begin
                if (found) begin
                    owner_n = winner;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                // A withdrawn request aborts without touching q or the pointer.
                if (req[owner]) begin
                    q_n          = slice[owner];
                    q_valid_n    = 1'b1;
                    ack_n        = '0;
                    ack_n[owner] = 1'b1;
                    state_n      = HOLD;
                end else begin
                    state_n = IDLE;
                end
            end
            HOLD: begin
                if (!req[owner]) begin
                    ack_n   = '0;
                    ptr_n   = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            ack     <= '0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            owner   <= owner_n;
            q       <= q_n;
            q_valid <= q_valid_n;
            ack     <= ack_n;
        end
    end

    assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dff_share_arb.sv
`default_nettype none
// ============================================================================
// Module     : tb_dff_share_arb
// Description: Self-checking bench for dff_share_arb with a transaction-level
//              reference model, directed scenarios and random traffic.
// Revision   : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_dff_share_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IW    = 2;

    logic                  clk   = 1'b0;
    logic                  reset = 1'b0;
    logic [NREQ-1:0]       req   = '0;
    logic [NREQ*WIDTH-1:0] wdata = '0;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      q;
    logic                  q_valid;
    logic [IW-1:0]         owner;
    logic                  busy;

    int checks   = 0;
    int failures = 0;

    dff_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wdata   (wdata),
        .ack     (ack),
        .q       (q),
        .q_valid (q_valid),
        .owner   (owner),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = free, 1 = granted awaiting load, 2 = holding.
    int               m_phase;
    int               m_owner;
    int               m_ptr;
    logic [WIDTH-1:0] m_q;
    logic             m_qv;

    function automatic int pick(input int p, input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0;
            m_owner <= 0;
            m_ptr   <= 0;
            m_q     <= '0;
            m_qv    <= 1'b0;
        end else if (m_phase == 0) begin
            if (req != '0) begin
                m_owner <= pick(m_ptr, req);
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            if (req[m_owner]) begin
                m_q     <= wdata[m_owner*WIDTH +: WIDTH];
                m_qv    <= 1'b1;
                m_phase <= 2;
            end else begin
                m_phase <= 0;
            end
        end else begin
            if (!req[m_owner]) begin
                m_phase <= 0;
                m_ptr   <= (m_owner + 1) % NREQ;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("model_ack", ack, (m_phase == 2) ? (32'd1 << m_owner) : 32'd0);
            chk("model_busy", busy, (m_phase != 0));
            chk("model_q", q, m_q);
            chk("model_q_valid", q_valid, m_qv);
            chk("model_owner", owner, m_owner);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        reset = 1'b0;
        chk("rst_ack", ack, 0);
        chk("rst_q", q, 0);
        chk("rst_q_valid", q_valid, 0);
        chk("rst_owner", owner, 0);
        chk("rst_busy", busy, 0);
    endtask

    task automatic wait_ack(input logic [NREQ-1:0] mask);
        int n = 0;
        while (ack !== mask && n < 20) begin
            tick();
            n++;
        end
        chk("wait_ack", ack, mask);
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got[$];
        int cyc;
        int exp_order[5] = '{0, 1, 2, 3, 0};

        #1;
        do_reset();

        // Single transaction, latency and release
        wdata[7:0] = 8'hA5;
        req = 4'b0001;
        tick();
        chk("e0_owner", owner, 0);
        chk("e0_busy", busy, 1);
        chk("e0_ack", ack, 0);
        tick();
        chk("e1_ack", ack, 4'b0001);
        chk("e1_q", q, 8'hA5);
        chk("e1_q_valid", q_valid, 1);
        req = 4'b0000;
        tick();
        chk("rel_ack", ack, 0);
        chk("rel_busy", busy, 0);

        // Round-robin with all requesting
        do_reset();
        for (int i = 0; i < NREQ; i++) wdata[i*WIDTH +: WIDTH] = 8'h10 + 8'(i);
        req = 4'b1111;
        cyc = 0;
        while (got.size() < 5 && cyc < 60) begin
            tick();
            cyc++;
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i] && req[i]) begin
                    got.push_back(i);
                    chk("rr_q", q, 8'h10 + 8'(i));
                    req[i] = 1'b0;
                end else if (!req[i] && !ack[i]) begin
                    req[i] = 1'b1;
                end
            end
        end
        chk("rr_count", got.size(), 5);
        for (int k = 0; k < got.size() && k < 5; k++) chk("rr_order", got[k], exp_order[k]);
        req = 4'b0000;
        tick();
        tick();
        chk("rr_idle", busy, 0);

        // Pointer wrap past requester 2 (ptr currently 1)
        req = 4'b0100;
        wait_ack(4'b0100);
        req = 4'b0000;
        tick();
        chk("w_busy", busy, 0);
        req = 4'b0101;
        tick();
        chk("wrap_owner", owner, 0);
        req = 4'b0001;
        tick();
        chk("wrap_ack", ack, 4'b0001);
        req = 4'b0000;
        tick();
        chk("wrap_rel", busy, 0);

        // Withdrawn request before LOAD
        req = 4'b0010;
        tick();
        chk("ab_owner0", owner, 1);
        chk("ab_busy0", busy, 1);
        req = 4'b0000;
        tick();
        chk("ab_busy", busy, 0);
        chk("ab_ack", ack, 0);
        chk("ab_q", q, 8'h10);
        chk("ab_owner", owner, 1);
        req = 4'b0110;
        tick();
        chk("ab_ptr_kept", owner, 1);
        tick();
        chk("ab_regrant", ack, 4'b0010);
        chk("ab_regrant_q", q, 8'h11);
        req = 4'b0000;
        tick();

        // wdata changes and competing req during HOLD
        wdata[3*WIDTH +: WIDTH] = 8'h3C;
        req = 4'b1000;
        wait_ack(4'b1000);
        wdata[3*WIDTH +: WIDTH] = 8'hC3;
        req = 4'b1001;
        tick();
        tick();
        tick();
        chk("hold_q", q, 8'h3C);
        chk("hold_ack", ack, 4'b1000);
        req = 4'b0001;
        tick();
        chk("hold_rel", ack, 0);
        tick();
        chk("next_owner", owner, 0);
        tick();
        chk("next_ack", ack, 4'b0001);
        chk("next_q", q, 8'h10);

        // Asynchronous reset mid-HOLD
        #1 reset = 1'b1;
        #1;
        chk("arst_ack", ack, 0);
        chk("arst_busy", busy, 0);
        chk("arst_q", q, 0);
        chk("arst_q_valid", q_valid, 0);
        #2 reset = 1'b0;
        req = 4'b1000;
        tick();
        chk("post_owner", owner, 3);
        tick();
        chk("post_ack", ack, 4'b1000);
        req = 4'b0000;
        tick();

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            wdata = {$urandom, $urandom};
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(3) == 0) req[i] = 1'b1;
                end else if (ack[i]) begin
                    if ($urandom_range(2) == 0) req[i] = 1'b0;
                end else begin
                    if ($urandom_range(7) == 0) req[i] = 1'b0;
                end
            end
        end
        req = '0;
        tick();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dff_share_arb.md
# dff_share_arb

Round-robin arbiter and write sequencer for a shared WIDTH-bit D-flip-flop register. Up to NREQ requesters compete for the register. The block grants one requester at a time, loads that requester's data into the register, and holds the grant under a 4-phase req/ack handshake until the requester releases it. It sits between the requester-side logic and the shared d/q storage, and it is the only writer of that storage.

## Interface
- NREQ, 4, number of requesters (≥2)
- WIDTH, 8, register width in bits
- IW, ceil(log2(NREQ)), width of the owner index (derived)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester request level; bit i belongs to requester i
- wdata  in  NREQ*WIDTH  requester i data on bits [i*WIDTH +: WIDTH]
- ack  out  NREQ  one-hot grant/acknowledge, registered
- q  out  WIDTH  shared register contents
- q_valid  out  1  high once the register has been loaded at least once since reset
- owner  out  IW  index of the current or most recent grantee
- busy  out  1  high while a grant is in progress (LOAD or HOLD)

## Operation
- States: IDLE, LOAD, HOLD.
- Reset values:
  - state=IDLE, round-robin pointer ptr=0
  - q=0, q_valid=0, ack=0, owner=0, busy=0
- Reset is asynchronous and clears all state and outputs immediately, including mid-LOAD or mid-HOLD.
- IDLE:
  - If req≠0, pick the winner: the first index i=ptr, ptr+1, … (wrapping NREQ-1→0) with req[i]=1.
  - Set owner←winner, busy←1, go to LOAD.
  - If req=0, stay in IDLE.
- LOAD:
  - If req[owner]=1: q←wdata slice of owner, q_valid←1, ack[owner]←1, go to HOLD.
  - If req[owner]=0 (withdrawn): abort. No load, q and q_valid unchanged, busy←0, ptr unchanged, go to IDLE.
- HOLD:
  - While req[owner]=1, stay; ack[owner] remains 1.
  - When req[owner]=0 is sampled: ack←0, busy←0, ptr←(owner+1) mod NREQ, go to IDLE.
- While busy, requests from other requesters are ignored; they remain pending and are arbitrated in the next IDLE.
- wdata is sampled only at the LOAD edge. Changes to wdata during HOLD do not affect q.
- q holds its value indefinitely between loads.
- q_valid never falls except on reset.
- ack is never asserted to more than one requester, and never to a requester whose req is low at the LOAD edge.

## Timing
- Edge E0: IDLE samples req. owner and busy are valid after E0.
- Edge E1: q, q_valid and ack[owner] update. req→ack latency is 2 edges; req→q latency is 2 edges.
- ack falls on the first edge at which req[owner]=0 is sampled in HOLD.
- The next grant is decided at the edge after ack falls, at the earliest.
- Minimum transaction is 4 cycles (IDLE, LOAD, HOLD with req dropped immediately, IDLE).
- Pointer wrap: after owner=NREQ-1 completes, ptr=0.
- Simultaneous requests are resolved purely by ptr order. There is no fixed priority, so a requester waits at most NREQ-1 transactions.
- A reset asserted between edges drives ack=0 and busy=0 without waiting for a clock edge. After reset deasserts, the first arbitration starts from ptr=0.

## Test plan
- Reset, then req=0001 with wdata[0]=8'hA5 → after 2 edges: ack=0001, q=A5, q_valid=1, owner=0. Drop req → ack=0000 next edge, busy=0.
- req=1111 held, each requester dropping req 1 cycle after its ack → grants occur in order 0,1,2,3,0. q takes each requester's data in turn. No two ack bits are ever high together.
- After a grant to requester 2 completes (ptr=3), assert req=0101 → next grant goes to 0 (wrap), not 2.
- Requester 1 raises req, then drops it in the cycle before LOAD → no ack, q unchanged, owner=1, busy returns to 0, ptr unchanged. The next req=0010 is granted normally.
- During HOLD for requester 3, change wdata[3] and raise req[0] → q keeps the original value. req[0] is granted only after req[3] drops.
- Assert reset mid-HOLD → ack, busy, q and q_valid go to 0 before the next clock edge. After reset deasserts, req=1000 is granted with owner=3 after 2 edges.
